// File: rtl/wr_data_queue.sv
`default_nettype none
// ============================================================================
// Module   : wr_data_queue
// Brief    : Shift-register write-data FIFO for the DDR5 data path. Words
//            are stored in arrival order. The head is always entry 0 and
//            advances on the downstream shift enable.
// Revision : 1.0 - initial release
// ============================================================================
module wr_data_queue #(
  parameter int DW     = 64,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wr_en,
  input  logic [DW-1:0]              i_wr_data,
  input  logic                       i_sh_en,
  output logic                       o_valid,
  output logic [DW-1:0]              o_rd_data,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] c_AF_LVL = CW'(AF_LVL);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] w_mem_nxt [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_wr_idx;
  logic          r_overflow;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_DEPTH);
  assign w_pop   = w_valid & i_sh_en;
  assign w_push  = i_wr_en & (~w_full | w_pop);
  assign w_drop  = i_wr_en & w_full & ~w_pop;

  // On a simultaneous pop, the incoming word lands one slot lower because the
  // whole array shifts down on the same edge.
  assign w_wr_idx = w_pop ? (r_count - CW'(1)) : r_count;

  // Next entry contents: optional shift down with zero fill, then optional write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_nxt[i] = r_mem[i];
      if (w_pop) begin
        w_mem_nxt[i] = (i < DEPTH - 1) ? r_mem[(i < DEPTH - 1) ? i + 1 : i] : '0;
      end
      if (w_push && (CW'(i) == w_wr_idx)) begin
        w_mem_nxt[i] = i_wr_data;
      end
    end
  end

  // Next occupancy; push and pop together leave the count unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Entry storage, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_nxt[i];
      end
      r_count <= w_count_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_valid       = w_valid;
  assign o_rd_data     = r_mem[0];
  assign o_full        = w_full;
  assign o_almost_full = (r_count >= c_AF_LVL);
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_wr_data_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wr_data_queue
// Brief    : Directed self-checking bench for wr_data_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wr_data_queue;

  localparam int DW    = 64;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          i_wr_en;
  logic [DW-1:0] i_wr_data;
  logic          i_sh_en;
  logic          o_valid;
  logic [DW-1:0] o_rd_data;
  logic          o_full;
  logic          o_almost_full;
  logic [3:0]    o_count;
  logic          o_overflow;

  int errors = 0;
  int checks = 0;

  wr_data_queue #(.DW(DW), .DEPTH(DEPTH), .AF_LVL(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_wr_en       (i_wr_en),
    .i_wr_data     (i_wr_data),
    .i_sh_en       (i_sh_en),
    .o_valid       (o_valid),
    .o_rd_data     (o_rd_data),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_count       (o_count),
    .o_overflow    (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      i_wr_en   = 1'b1;
      i_wr_data = DW'(first + k);
      tick();
    end
    i_wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_wr_en = 1'b1; i_wr_data = 64'h77; i_sh_en = 1'b0;

    // Reset held for two edges with a push request present.
    tick(); tick();
    rst = 1'b1; i_wr_en = 1'b0;
    chk("rst_count",    64'(o_count), 64'd0);
    chk("rst_valid",    64'(o_valid), 64'd0);
    chk("rst_rd_data",  o_rd_data, 64'd0);
    chk("rst_overflow", 64'(o_overflow), 64'd0);
    chk("rst_full",     64'(o_full), 64'd0);
    chk("rst_af",       64'(o_almost_full), 64'd0);

    // Single word push then pop.
    i_wr_en = 1'b1; i_wr_data = 64'hA5;
    chk("nofall_valid", 64'(o_valid), 64'd0);
    tick();
    i_wr_en = 1'b0;
    chk("single_valid", 64'(o_valid), 64'd1);
    chk("single_data",  o_rd_data, 64'hA5);
    chk("single_count", 64'(o_count), 64'd1);
    i_sh_en = 1'b1;
    tick();
    i_sh_en = 1'b0;
    chk("single_pop_valid", 64'(o_valid), 64'd0);
    chk("single_pop_count", 64'(o_count), 64'd0);
    chk("single_pop_data",  o_rd_data, 64'd0);

    // Fill 1..9 with no pops; word 9 is dropped.
    for (int k = 1; k <= 9; k++) begin
      i_wr_en = 1'b1; i_wr_data = DW'(k);
      tick();
      chk("fill_count", 64'(o_count), 64'((k > 8) ? 8 : k));
      chk("fill_af",    64'(o_almost_full), 64'((k >= 6) ? 1 : 0));
      chk("fill_full",  64'(o_full), 64'((k >= 8) ? 1 : 0));
      chk("fill_ovf",   64'(o_overflow), 64'((k == 9) ? 1 : 0));
    end
    i_wr_en = 1'b0;
    // Drain in order.
    i_sh_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("drain_data", o_rd_data, DW'(k));
      tick();
    end
    i_sh_en = 1'b0;
    chk("drain_count", 64'(o_count), 64'd0);
    chk("drain_valid", 64'(o_valid), 64'd0);
    chk("drain_ovf_sticky", 64'(o_overflow), 64'd1);

    // Clear overflow.
    rst = 1'b0; tick(); rst = 1'b1;
    chk("clr_ovf", 64'(o_overflow), 64'd0);

    // Push and pop together while full.
    push_n(1, 8);
    chk("full_pre", 64'(o_full), 64'd1);
    i_wr_en = 1'b1; i_wr_data = 64'h99; i_sh_en = 1'b1;
    tick();
    i_wr_en = 1'b0; i_sh_en = 1'b0;
    chk("pp_full_count", 64'(o_count), 64'd8);
    chk("pp_full_head",  o_rd_data, 64'd2);
    chk("pp_full_ovf",   64'(o_overflow), 64'd0);
    i_sh_en = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk("pp_full_drain", o_rd_data, (k == 9) ? 64'h99 : DW'(k));
      tick();
    end
    i_sh_en = 1'b0;
    chk("pp_full_empty", 64'(o_count), 64'd0);

    // Push and pop together at count 1.
    i_wr_en = 1'b1; i_wr_data = 64'h11;
    tick();
    i_wr_data = 64'h22; i_sh_en = 1'b1;
    tick();
    i_wr_en = 1'b0; i_sh_en = 1'b0;
    chk("pp1_count", 64'(o_count), 64'd1);
    chk("pp1_data",  o_rd_data, 64'h22);
    i_sh_en = 1'b1; tick(); i_sh_en = 1'b0;
    chk("pp1_empty", 64'(o_count), 64'd0);

    // Reset mid-operation: overflow set, count 5, push on the reset edge.
    push_n(1, 9);
    i_sh_en = 1'b1;
    tick(); tick(); tick();
    i_sh_en = 1'b0;
    chk("mid_count",   64'(o_count), 64'd5);
    chk("mid_head",    o_rd_data, 64'd4);
    chk("mid_ovf",     64'(o_overflow), 64'd1);
    rst = 1'b0; i_wr_en = 1'b1; i_wr_data = 64'hEE;
    tick();
    rst = 1'b1; i_wr_en = 1'b0;
    chk("midrst_count", 64'(o_count), 64'd0);
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ovf",   64'(o_overflow), 64'd0);
    chk("midrst_data",  o_rd_data, 64'd0);
    tick();
    chk("midrst_lost",  64'(o_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wr_data_queue.md
# wr_data_queue

Write-data queue feeding the burst strobe logic of the DDR5 controller data path. Stores write-data words from the front end in arrival order and presents the oldest word with `valid` to the downstream queue logic. Advances on that stage's shift enable, so each burst leaves exactly once. Implemented as a shift-register FIFO; the head is always entry 0.

## Interface
- `DW`, 64, width of one write-data word.
- `DEPTH`, 8, number of entries; must be a power of two, at least 2.
- `AF_LVL`, 6, count at or above which `almost_full` asserts; range 1..DEPTH.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-low; clock `clk`.
- `wr_en` input 1: push request from the front end.
- `wr_data` input DW: word to push; sampled on the edge where `wr_en`=1.
- `sh_en` input 1: shift enable from the downstream queue logic; high while that stage is idle.
- `valid` output 1: head entry holds a word; equals `count != 0`.
- `rd_data` output DW: head word (entry 0); 0 when empty.
- `full` output 1: `count == DEPTH`.
- `almost_full` output 1: `count >= AF_LVL`.
- `count` output $clog2(DEPTH)+1: number of stored words.
- `overflow` output 1: sticky error flag, set on a dropped push.

## Operation
- `pop = valid & sh_en`. Downstream leaves idle on the same edge, so pop and burst launch coincide.
- `push = wr_en & (!full | pop)`. A push while full with no pop is dropped and sets `overflow`.
- Push only: word written to entry[count]; count+1.
- Pop only: entry[i] <= entry[i+1] for i < count-1. The vacated top entry is cleared to 0; count-1.
- Push and pop on the same edge:
  - entries shift down;
  - `wr_data` is written to entry[count-1];
  - count unchanged.
  - This holds at full, and at count=1, where `wr_data` becomes the new head.
- There is no fall-through. A word pushed into an empty queue is not visible until the following cycle.
- `overflow` stays set until reset. `wr_en` while full has no other side effect.
- Entries at or above `count` are held at 0, so `rd_data` is 0 when empty.
- Count arithmetic is unsigned, width $clog2(DEPTH)+1, and never wraps: guarded by the full and valid conditions.

## Timing
- Reset on an edge with `rst`=0: every entry, `count`, and `overflow` become 0. Consequently `valid`=0, `full`=0, `almost_full`=0, and `rd_data`=0.
- Reset overrides a push or pop on the same edge.
- Reset mid-burst discards all stored words. Downstream resets on the same edge.
- Push latency: `wr_en` sampled at edge N, so `valid`=1 and `rd_data`=`wr_data` after edge N.
- Pop: with `valid`&`sh_en` at edge N, `rd_data` shows the next word after edge N.
- After a pop, downstream holds `sh_en` low for BL/2 cycles. The queue therefore sustains one pop per BL/2+1 cycles; no extra throttling is done here.
- All outputs are registered state or direct decodes of `count`; no combinational path from `wr_en` or `sh_en` to any output.
- The front end must deassert `wr_en` based on `almost_full`, which allows DEPTH-AF_LVL words of push-pipeline slack.

## Test plan
- Reset: assert `rst`=0 for 2 cycles with `wr_en`=1 -> `count`=0, `valid`=0, `rd_data`=0, and `overflow`=0 after release.
- Single word: `sh_en`=0, push 0xA5 -> `valid`=1 and `rd_data`=0xA5 next cycle; raise `sh_en` for 1 cycle -> `valid`=0, `count`=0, `rd_data`=0.
- Fill and overflow: `sh_en`=0, push 1..9 on consecutive cycles.
  - `almost_full` rises after word 6 and `full` after word 8.
  - Word 9 is dropped; `overflow`=1 and `count`=8.
  - Drain with `sh_en`=1 -> words read out 1..8 in order.
- Push and pop at full: `count`=8 with head=1; `wr_en`=1 with data 0x99, `sh_en`=1 on one edge.
  - `count` stays 8, head=2, and entry 7=0x99.
  - `overflow` stays 0.
- Push and pop at count=1 (head 0x11), push 0x22 with `sh_en`=1 -> `count`=1, `rd_data`=0x22.
- Reset mid-operation: `count`=5, assert `rst`=0 for one edge during a push -> `count`=0, `valid`=0, `overflow` cleared; the pushed word is lost.
